// File: rtl/hetic_arbiter_if.sv
// rtl/hetic_arbiter_if.sv - bus bundle between HETIC register file, arbiter and core
interface hetic_arbiter_if #(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int NestDepth  = 4
);
  localparam int IrqWidth   = $clog2(NrIrqLines);
  localparam int PrioWidth  = $clog2(NrIrqPrios);
  localparam int DepthWidth = $clog2(NestDepth + 1);

  logic [NrIrqLines-1:0]           ie_i;
  logic [NrIrqLines-1:0]           ip_i;
  logic [NrIrqLines-1:0]           heti_i;
  logic [NrIrqLines-1:0]           nest_i;
  logic [NrIrqLines*PrioWidth-1:0] prio_i;
  logic                            irq_valid_o;
  logic [IrqWidth-1:0]             irq_id_o;
  logic                            irq_heti_o;
  logic                            irq_nest_o;
  logic [PrioWidth-1:0]            irq_prio_o;
  logic                            irq_ack_i;
  logic [IrqWidth-1:0]             irq_id_i;
  logic                            irq_done_i;
  logic                            clr_valid_o;
  logic [IrqWidth-1:0]             clr_id_o;
  logic [PrioWidth-1:0]            level_o;
  logic [DepthWidth-1:0]           depth_o;

  // arbiter side
  modport master (
    input  ie_i, ip_i, heti_i, nest_i, prio_i, irq_ack_i, irq_id_i, irq_done_i,
    output irq_valid_o, irq_id_o, irq_heti_o, irq_nest_o, irq_prio_o,
    output clr_valid_o, clr_id_o, level_o, depth_o
  );

  // register file / core side
  modport slave (
    output ie_i, ip_i, heti_i, nest_i, prio_i, irq_ack_i, irq_id_i, irq_done_i,
    input  irq_valid_o, irq_id_o, irq_heti_o, irq_nest_o, irq_prio_o,
    input  clr_valid_o, clr_id_o, level_o, depth_o
  );
endinterface

// File: rtl/hetic_arbiter.sv
// rtl/hetic_arbiter.sv - priority arbiter and nesting scheduler for HETIC
module hetic_arbiter #(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int NestDepth  = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  hetic_arbiter_if.master bus
);
  localparam int IrqWidth   = $clog2(NrIrqLines);
  localparam int PrioWidth  = $clog2(NrIrqPrios);
  localparam int DepthWidth = $clog2(NestDepth + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, CLAIM, SETTLE} state_e;

  state_e state_q, state_d;

  // stack of active handler levels; entry depth-1 is the innermost
  logic [PrioWidth-1:0]  stk_prio_q [NestDepth];
  logic [PrioWidth-1:0]  stk_prio_d [NestDepth];
  logic                  stk_nest_q [NestDepth];
  logic                  stk_nest_d [NestDepth];
  logic [DepthWidth-1:0] depth_q, depth_d;

  logic                  cand_found_q, cand_found_d;
  logic [IrqWidth-1:0]   cand_id_q, cand_id_d;
  logic [PrioWidth-1:0]  cand_prio_q, cand_prio_d;
  logic                  cand_heti_q, cand_heti_d;
  logic                  cand_nest_q, cand_nest_d;
  logic [IrqWidth-1:0]   claim_id_q, claim_id_d;

  logic [PrioWidth-1:0]  top_prio;
  logic                  top_nest;
  logic                  stack_empty;
  logic                  stack_full;
  logic [PrioWidth-1:0]  line_prio;
  logic                  line_elig;
  logic [PrioWidth-1:0]  ack_prio;
  logic                  ack_nest;
  logic                  ack_take;

  assign stack_empty = (depth_q == '0);
  assign stack_full  = (depth_q == DepthWidth'(NestDepth));

  // innermost active level; zero when nothing is active
  always_comb begin
    top_prio = '0;
    top_nest = 1'b0;
    for (int i = 0; i < NestDepth; i++) begin
      if (DepthWidth'(i + 1) == depth_q) begin
        top_prio = stk_prio_q[i];
        top_nest = stk_nest_q[i];
      end
    end
  end

  // pick the highest-priority eligible line, lowest index on ties
  always_comb begin
    cand_found_d = 1'b0;
    cand_id_d    = '0;
    cand_prio_d  = '0;
    cand_heti_d  = 1'b0;
    cand_nest_d  = 1'b0;
    line_prio    = '0;
    line_elig    = 1'b0;
    for (int n = 0; n < NrIrqLines; n++) begin
      line_prio = bus.prio_i[n*PrioWidth +: PrioWidth];
      line_elig = bus.ie_i[n] && bus.ip_i[n] && (line_prio != '0) &&
                  (stack_empty || (top_nest && (line_prio > top_prio) && !stack_full));
      if (line_elig && (!cand_found_d || (line_prio > cand_prio_d))) begin
        cand_found_d = 1'b1;
        cand_id_d    = IrqWidth'(n);
        cand_prio_d  = line_prio;
        cand_heti_d  = bus.heti_i[n];
        cand_nest_d  = bus.nest_i[n];
      end
    end
  end

  // attributes of the line the core claims; the core's id is authoritative
  always_comb begin
    ack_prio = '0;
    ack_nest = 1'b0;
    for (int n = 0; n < NrIrqLines; n++) begin
      if (IrqWidth'(n) == bus.irq_id_i) begin
        ack_prio = bus.prio_i[n*PrioWidth +: PrioWidth];
        ack_nest = bus.nest_i[n];
      end
    end
  end

  // handshake FSM and handler stack next state
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    stk_prio_d = stk_prio_q;
    stk_nest_d = stk_nest_q;
    claim_id_d = claim_id_q;
    ack_take   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cand_found_d) state_d = PRESENT;
      end
      PRESENT: begin
        if (bus.irq_ack_i) begin
          ack_take   = 1'b1;
          claim_id_d = bus.irq_id_i;
          state_d    = CLAIM;
        end else if (!cand_found_d) begin
          state_d = IDLE;
        end
      end
      CLAIM: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = cand_found_d ? PRESENT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // a claim and a completion in the same cycle cancel out (push then pop)
    if (!(ack_take && bus.irq_done_i)) begin
      if (ack_take) begin
        if (!stack_full) begin
          for (int i = 0; i < NestDepth; i++) begin
            if (DepthWidth'(i) == depth_q) begin
              stk_prio_d[i] = ack_prio;
              stk_nest_d[i] = ack_nest;
            end
          end
          depth_d = depth_q + 1'b1;
        end
      end else if (bus.irq_done_i && !stack_empty) begin
        depth_d = depth_q - 1'b1;
      end
    end
  end

  // state, stack and candidate registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      depth_q      <= '0;
      cand_found_q <= 1'b0;
      cand_id_q    <= '0;
      cand_prio_q  <= '0;
      cand_heti_q  <= 1'b0;
      cand_nest_q  <= 1'b0;
      claim_id_q   <= '0;
      for (int i = 0; i < NestDepth; i++) begin
        stk_prio_q[i] <= '0;
        stk_nest_q[i] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      cand_found_q <= cand_found_d;
      cand_id_q    <= cand_id_d;
      cand_prio_q  <= cand_prio_d;
      cand_heti_q  <= cand_heti_d;
      cand_nest_q  <= cand_nest_d;
      claim_id_q   <= claim_id_d;
      stk_prio_q   <= stk_prio_d;
      stk_nest_q   <= stk_nest_d;
    end
  end

  assign bus.irq_valid_o = (state_q == PRESENT) && cand_found_q;
  assign bus.irq_id_o    = bus.irq_valid_o ? cand_id_q   : '0;
  assign bus.irq_prio_o  = bus.irq_valid_o ? cand_prio_q : '0;
  assign bus.irq_heti_o  = bus.irq_valid_o && cand_heti_q;
  assign bus.irq_nest_o  = bus.irq_valid_o && cand_nest_q;
  assign bus.clr_valid_o = (state_q == CLAIM);
  assign bus.clr_id_o    = bus.clr_valid_o ? claim_id_q : '0;
  assign bus.level_o     = top_prio;
  assign bus.depth_o     = depth_q;
endmodule

// File: tb/tb_hetic_arbiter.sv
// tb/tb_hetic_arbiter.sv - self-checking bench for hetic_arbiter
module tb_hetic_arbiter;
  localparam int NL = 64;
  localparam int NP = 32;
  localparam int ND = 4;
  localparam int PW = 5;

  logic clk;
  logic rst_n;

  hetic_arbiter_if #(.NrIrqLines(NL), .NrIrqPrios(NP), .NestDepth(ND)) bus ();

  hetic_arbiter #(.NrIrqLines(NL), .NrIrqPrios(NP), .NestDepth(ND)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: stack of {prio, nest}, presented winner, claim blackout
  int stk_p[$];
  bit stk_n[$];
  bit m_valid;
  int m_id;
  int m_prio;
  bit m_heti;
  bit m_nest;
  bit m_clr;
  int m_clr_id;
  int m_blk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    stk_p.delete();
    stk_n.delete();
    m_valid = 0; m_id = 0; m_prio = 0; m_heti = 0; m_nest = 0;
    m_clr = 0; m_clr_id = 0; m_blk = 0;
  endtask

  task automatic check_all();
    chk("valid", 32'(bus.irq_valid_o), 32'(m_valid));
    chk("id", 32'(bus.irq_id_o), m_id);
    chk("prio", 32'(bus.irq_prio_o), m_prio);
    chk("heti", 32'(bus.irq_heti_o), 32'(m_heti));
    chk("nest", 32'(bus.irq_nest_o), 32'(m_nest));
    chk("clr_valid", 32'(bus.clr_valid_o), 32'(m_clr));
    chk("clr_id", 32'(bus.clr_id_o), m_clr_id);
    chk("level", 32'(bus.level_o), (stk_p.size() > 0) ? stk_p[$] : 0);
    chk("depth", 32'(bus.depth_o), stk_p.size());
  endtask

  // advance one clock: predict from current inputs, compare after the edge
  task automatic step();
    int best, bp, tp, p;
    bit tn, elig, acc;
    best = -1; bp = 0; tp = 0; tn = 0;
    if (stk_p.size() > 0) begin
      tp = stk_p[$];
      tn = stk_n[$];
    end
    for (int n = 0; n < NL; n++) begin
      p = int'(bus.prio_i[n*PW +: PW]);
      elig = bus.ie_i[n] && bus.ip_i[n] && (p != 0) &&
             (stk_p.size() == 0 || (tn && p > tp && stk_p.size() < ND));
      if (elig && p > bp) begin
        best = n;
        bp   = p;
      end
    end
    acc = bus.irq_ack_i && m_valid;
    if (!(acc && bus.irq_done_i)) begin
      if (acc) begin
        if (stk_p.size() < ND) begin
          stk_p.push_back(int'(bus.prio_i[int'(bus.irq_id_i)*PW +: PW]));
          stk_n.push_back(bus.nest_i[bus.irq_id_i]);
        end
      end else if (bus.irq_done_i && stk_p.size() > 0) begin
        void'(stk_p.pop_back());
        void'(stk_n.pop_back());
      end
    end
    m_clr    = acc;
    m_clr_id = acc ? int'(bus.irq_id_i) : 0;
    m_blk    = acc ? 2 : ((m_blk > 0) ? m_blk - 1 : 0);
    m_valid  = (m_blk == 0) && (best >= 0);
    m_id     = m_valid ? best : 0;
    m_prio   = m_valid ? bp : 0;
    m_heti   = m_valid ? bus.heti_i[best] : 1'b0;
    m_nest   = m_valid ? bus.nest_i[best] : 1'b0;
    @(posedge clk);
    #1;
    check_all();
    if (m_clr) bus.ip_i[m_clr_id] = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.ie_i = '0; bus.ip_i = '0; bus.heti_i = '0; bus.nest_i = '0; bus.prio_i = '0;
    bus.irq_ack_i = 1'b0; bus.irq_id_i = '0; bus.irq_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", 32'(bus.irq_valid_o), 0);
    chk("rst_clr", 32'(bus.clr_valid_o), 0);
    chk("rst_depth", 32'(bus.depth_o), 0);
    chk("rst_level", 32'(bus.level_o), 0);
  endtask

  task automatic set_line(input int n, input int p, input bit nst, input bit ht);
    bus.prio_i[n*PW +: PW] = PW'(p);
    bus.nest_i[n] = nst;
    bus.heti_i[n] = ht;
  endtask

  task automatic pend(input int n);
    bus.ie_i[n] = 1'b1;
    bus.ip_i[n] = 1'b1;
  endtask

  task automatic claim();
    bus.irq_ack_i = 1'b1;
    bus.irq_id_i  = 6'(m_id);
    step();
    bus.irq_ack_i = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_clear();
    #12;
    do_reset();

    // single line, claim and clear pulse
    set_line(5, 3, 1'b1, 1'b1);
    pend(5);
    step();
    chk("single_valid", 32'(bus.irq_valid_o), 1);
    chk("single_id", 32'(bus.irq_id_o), 5);
    chk("single_prio", 32'(bus.irq_prio_o), 3);
    bus.irq_ack_i = 1'b1;
    bus.irq_id_i  = 6'd5;
    step();
    bus.irq_ack_i = 1'b0;
    chk("single_clr", 32'(bus.clr_valid_o), 1);
    chk("single_clr_id", 32'(bus.clr_id_o), 5);
    chk("single_level", 32'(bus.level_o), 3);
    chk("single_depth", 32'(bus.depth_o), 1);
    step();
    step();

    // nesting over a nestable prio-3 handler, then a non-nestable one
    set_line(12, 5, 1'b0, 1'b0);
    set_line(13, 3, 1'b1, 1'b0);
    pend(12);
    pend(13);
    step();
    chk("nest_id", 32'(bus.irq_id_o), 12);
    claim();
    set_line(14, 9, 1'b1, 1'b0);
    pend(14);
    step();
    step();
    chk("nest0_block", 32'(bus.irq_valid_o), 0);
    bus.irq_done_i = 1'b1;
    step();
    bus.irq_done_i = 1'b0;
    step();
    chk("nest_after_done", 32'(bus.irq_id_o), 14);
    step();

    // tie-break to lowest index, then replacement without a gap
    do_reset();
    set_line(9, 7, 1'b0, 1'b0);
    set_line(4, 7, 1'b0, 1'b1);
    pend(9);
    pend(4);
    step();
    chk("tie_id", 32'(bus.irq_id_o), 4);
    set_line(20, 8, 1'b0, 1'b0);
    pend(20);
    step();
    chk("replace_valid", 32'(bus.irq_valid_o), 1);
    chk("replace_id", 32'(bus.irq_id_o), 20);

    // depth limit
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_line(30 + k, 2 + 2 * k, 1'b1, 1'b0);
      pend(30 + k);
      step();
      claim();
    end
    chk("full_depth", 32'(bus.depth_o), 4);
    set_line(34, 10, 1'b1, 1'b0);
    pend(34);
    for (int k = 0; k < 3; k++) step();
    chk("full_block", 32'(bus.irq_valid_o), 0);
    bus.irq_done_i = 1'b1;
    step();
    bus.irq_done_i = 1'b0;
    chk("full_done_lat", 32'(bus.irq_valid_o), 0);
    step();
    chk("full_done_valid", 32'(bus.irq_valid_o), 1);
    chk("full_done_id", 32'(bus.irq_id_o), 34);

    // done underflow, then ack and done together
    do_reset();
    bus.irq_done_i = 1'b1;
    step();
    bus.irq_done_i = 1'b0;
    chk("underflow_depth", 32'(bus.depth_o), 0);
    set_line(40, 2, 1'b1, 1'b0);
    pend(40);
    step();
    claim();
    set_line(41, 6, 1'b1, 1'b1);
    pend(41);
    step();
    chk("simul_pre_id", 32'(bus.irq_id_o), 41);
    bus.irq_ack_i  = 1'b1;
    bus.irq_id_i   = 6'd41;
    bus.irq_done_i = 1'b1;
    step();
    bus.irq_ack_i  = 1'b0;
    bus.irq_done_i = 1'b0;
    chk("simul_depth", 32'(bus.depth_o), 1);
    chk("simul_level", 32'(bus.level_o), 2);
    step();
    step();

    // asynchronous reset during CLAIM
    do_reset();
    set_line(50, 4, 1'b0, 1'b1);
    pend(50);
    step();
    bus.irq_ack_i = 1'b1;
    bus.irq_id_i  = 6'd50;
    step();
    bus.irq_ack_i = 1'b0;
    chk("areset_pre_clr", 32'(bus.clr_valid_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_clr", 32'(bus.clr_valid_o), 0);
    chk("areset_depth", 32'(bus.depth_o), 0);
    chk("areset_level", 32'(bus.level_o), 0);
    chk("areset_valid", 32'(bus.irq_valid_o), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < NL; n++) set_line(n, int'($urandom_range(0, NP - 1)), 1'($urandom), 1'($urandom));
    bus.ie_i = {$urandom, $urandom};
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.ip_i[$urandom_range(0, NL - 1)] = 1'b1;
      if ($urandom_range(0, 49) == 0) bus.ie_i[$urandom_range(0, NL - 1)] ^= 1'b1;
      if ((m_valid && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0) begin
        bus.irq_ack_i = 1'b1;
        bus.irq_id_i  = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, NL - 1)) : 6'(m_id);
      end else begin
        bus.irq_ack_i = 1'b0;
      end
      bus.irq_done_i = ($urandom_range(0, 6) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
